// File: rtl/gate_truth_table_sequencer.sv
// Self-test sequencer for a 2-input gate: walks vectors 00..11,
// samples the gate after a settle interval and checks a truth table.
module gate_truth_table_sequencer #(
    parameter int         SETTLE_CYCLES = 2,
    parameter logic [3:0] TRUTH_TABLE   = 4'b0111
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       dut_out,
    output logic       in_a,
    output logic       in_b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [1:0] fail_index,
    output logic [2:0] fail_count,
    output logic [3:0] observed
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SAMPLE,
        FINISH
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] vec;
    logic [3:0] cnt;
    logic       first_fail_seen;
    logic       mismatch;
    logic [2:0] fail_count_nxt;

    assign mismatch       = (dut_out != TRUTH_TABLE[vec]);
    assign fail_count_nxt = fail_count + {2'b00, mismatch};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISH: begin
                if (start) state_nxt = APPLY;
            end
            APPLY:  state_nxt = SETTLE;
            SETTLE: begin
                if (cnt == 4'd0) state_nxt = SAMPLE;
            end
            SAMPLE: state_nxt = (vec == 2'd3) ? FINISH : APPLY;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            APPLY, SETTLE, SAMPLE: busy = 1'b1;
            FINISH:                done = 1'b1;
            default: ;
        endcase
    end

    // Results update only on SAMPLE exit; a restart wipes them at the accepting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vec             <= 2'd0;
            cnt             <= 4'd0;
            in_a            <= 1'b0;
            in_b            <= 1'b0;
            pass            <= 1'b0;
            fail_index      <= 2'd0;
            fail_count      <= 3'd0;
            observed        <= 4'd0;
            first_fail_seen <= 1'b0;
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        vec             <= 2'd0;
                        in_a            <= 1'b0;
                        in_b            <= 1'b0;
                        pass            <= 1'b0;
                        fail_index      <= 2'd0;
                        fail_count      <= 3'd0;
                        observed        <= 4'd0;
                        first_fail_seen <= 1'b0;
                    end
                end
                APPLY: begin
                    cnt <= 4'(SETTLE_CYCLES - 1);
                end
                SETTLE: begin
                    if (cnt != 4'd0) cnt <= cnt - 4'd1;
                end
                SAMPLE: begin
                    observed[vec] <= dut_out;
                    fail_count    <= fail_count_nxt;
                    if (mismatch && !first_fail_seen) begin
                        fail_index      <= vec;
                        first_fail_seen <= 1'b1;
                    end
                    if (vec != 2'd3) begin
                        vec          <= vec + 2'd1;
                        {in_a, in_b} <= vec + 2'd1;
                    end else begin
                        pass <= (fail_count_nxt == 3'd0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_truth_table_sequencer.sv
// Directed bench for gate_truth_table_sequencer: Nand/And/tie-1 gate
// models on a default instance, Xor on a SETTLE_CYCLES=1 instance.
module tb_gate_truth_table_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       dut_out;
    logic       in_a;
    logic       in_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [1:0] fail_index;
    logic [2:0] fail_count;
    logic [3:0] observed;

    logic       start1;
    logic       dut_out1;
    logic       in_a1;
    logic       in_b1;
    logic       busy1;
    logic       done1;
    logic       pass1;
    logic [1:0] fail_index1;
    logic [2:0] fail_count1;
    logic [3:0] observed1;

    int checks;
    int errors;
    int mode;

    gate_truth_table_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dut_out    (dut_out),
        .in_a       (in_a),
        .in_b       (in_b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .fail_index (fail_index),
        .fail_count (fail_count),
        .observed   (observed)
    );

    gate_truth_table_sequencer #(
        .SETTLE_CYCLES (1),
        .TRUTH_TABLE   (4'b0110)
    ) dut1 (
        .clk        (clk),
        .reset      (reset),
        .start      (start1),
        .dut_out    (dut_out1),
        .in_a       (in_a1),
        .in_b       (in_b1),
        .busy       (busy1),
        .done       (done1),
        .pass       (pass1),
        .fail_index (fail_index1),
        .fail_count (fail_count1),
        .observed   (observed1)
    );

    // Gate models: 0 = Nand, 1 = And, 2 = tied high
    always_comb begin
        case (mode)
            0:       dut_out = ~(in_a & in_b);
            1:       dut_out = in_a & in_b;
            default: dut_out = 1'b1;
        endcase
    end

    assign dut_out1 = in_a1 ^ in_b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({in_a, in_b, busy, done, pass, fail_index, fail_count, observed}
            !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want all zero",
                {in_a, in_b, busy, done, pass, fail_index, fail_count, observed});
        end
        reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%b done=%b want 0 0",
                busy, done);
        end
    endtask

    task automatic test_nand();
        logic [1:0] exp_vec;
        mode = 0;
        pulse_start();
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) tick();
            exp_vec = (k < 16) ? 2'(k / 4) : 2'd3;
            checks++;
            if ({in_a, in_b} !== exp_vec) begin
                errors++;
                $display("FAIL nand_vec_k%0d: got %b want %b",
                    k, {in_a, in_b}, exp_vec);
            end
            checks++;
            if (busy !== (k < 16) || done !== (k == 16)) begin
                errors++;
                $display("FAIL nand_busy_done_k%0d: got %b%b want %b%b",
                    k, busy, done, k < 16, k == 16);
            end
        end
        checks++;
        if (pass !== 1'b1 || observed !== 4'b0111 ||
            fail_count !== 3'd0 || fail_index !== 2'd0) begin
            errors++;
            $display("FAIL nand_result: pass=%b obs=%b cnt=%0d idx=%0d want 1 0111 0 0",
                pass, observed, fail_count, fail_index);
        end
    endtask

    task automatic test_and();
        mode = 1;
        pulse_start();
        repeat (16) tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || observed !== 4'b1000 ||
            fail_count !== 3'd4 || fail_index !== 2'd0) begin
            errors++;
            $display("FAIL and_result: done=%b pass=%b obs=%b cnt=%0d idx=%0d want 1 0 1000 4 0",
                done, pass, observed, fail_count, fail_index);
        end
    endtask

    task automatic test_tie_high();
        mode = 2;
        pulse_start();
        repeat (16) tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b0 || observed !== 4'b1111 ||
            fail_count !== 3'd1 || fail_index !== 2'd3) begin
            errors++;
            $display("FAIL tie1_result: done=%b pass=%b obs=%b cnt=%0d idx=%0d want 1 0 1111 1 3",
                done, pass, observed, fail_count, fail_index);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        mode = 2;
        start = 1'b1;
        tick();
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            tick();
            edges++;
        end
        checks++;
        if (edges != 16) begin
            errors++;
            $display("FAIL held_start_latency: got %0d edges want 16", edges);
        end
        checks++;
        if (busy !== 1'b0 || observed !== 4'b1111 || fail_count !== 3'd1 ||
            fail_index !== 2'd3) begin
            errors++;
            $display("FAIL held_start_single_run: busy=%b obs=%b cnt=%0d idx=%0d want 0 1111 1 3",
                busy, observed, fail_count, fail_index);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || observed !== 4'd0 ||
            fail_count !== 3'd0 || fail_index !== 2'd0 || {in_a, in_b} !== 2'b00) begin
            errors++;
            $display("FAIL held_start_restart: done=%b busy=%b obs=%b cnt=%0d idx=%0d in=%b want 0 1 0 0 0 00",
                done, busy, observed, fail_count, fail_index, {in_a, in_b});
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        mode = 0;
        pulse_start();
        repeat (9) tick();
        checks++;
        if ({in_a, in_b} !== 2'b10 || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_run_position: in=%b busy=%b want 10 1",
                {in_a, in_b}, busy);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({in_a, in_b, busy, done, pass, fail_index, fail_count, observed}
            !== 14'd0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %b want all zero",
                {in_a, in_b, busy, done, pass, fail_index, fail_count, observed});
        end
        #1;
        reset = 1'b0;
        tick();
        pulse_start();
        checks++;
        if ({in_a, in_b} !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_start: in=%b busy=%b want 00 1",
                {in_a, in_b}, busy);
        end
        repeat (16) tick();
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || observed !== 4'b0111 ||
            fail_count !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_result: done=%b pass=%b obs=%b cnt=%0d want 1 1 0111 0",
                done, pass, observed, fail_count);
        end
    endtask

    task automatic test_settle_one_xor();
        logic [1:0] exp_vec;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) tick();
            exp_vec = (k < 12) ? 2'(k / 3) : 2'd3;
            checks++;
            if ({in_a1, in_b1} !== exp_vec) begin
                errors++;
                $display("FAIL xor_vec_k%0d: got %b want %b",
                    k, {in_a1, in_b1}, exp_vec);
            end
            checks++;
            if (done1 !== (k == 12) || busy1 !== (k < 12)) begin
                errors++;
                $display("FAIL xor_busy_done_k%0d: got %b%b want %b%b",
                    k, busy1, done1, k < 12, k == 12);
            end
        end
        checks++;
        if (pass1 !== 1'b1 || observed1 !== 4'b0110 ||
            fail_count1 !== 3'd0 || fail_index1 !== 2'd0) begin
            errors++;
            $display("FAIL xor_result: pass=%b obs=%b cnt=%0d idx=%0d want 1 0110 0 0",
                pass1, observed1, fail_count1, fail_index1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mode   = 0;
        start  = 1'b0;
        start1 = 1'b0;
        reset  = 1'b1;
        test_reset();
        test_nand();
        test_and();
        test_tie_high();
        test_back_to_back();
        test_reset_mid_run();
        test_settle_one_xor();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_truth_table_sequencer.md
Name: gate_truth_table_sequencer

Overview:
Synthesizable self-test controller for any 2-input combinational gate in the hardware platform (Nand first, then And/Or/Xor built on it). On a start pulse it drives the gate's two inputs through all four vectors in order 00, 01, 10, 11. After a settle interval it samples the gate output for each vector and compares it against a parameterized truth table. It then reports pass/fail, the first failing vector and the mismatch count. It replaces hand-written delay-based benches with a clocked, reusable sequencer for hardware bring-up.

Parameters:
SETTLE_CYCLES, 2, cycles in SETTLE per vector; legal range 1..15.
TRUTH_TABLE, 4'b0111, expected gate output; bit i is the expected out for {in_a,in_b} = i (default = Nand).

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; forces all state and outputs to reset values immediately
start  input  1  request a test run; sampled only in IDLE or DONE
dut_out  input  1  output of the gate under test
in_a  output  1  registered drive to gate input a (vector MSB)
in_b  output  1  registered drive to gate input b (vector LSB)
busy  output  1  high in APPLY, SETTLE and SAMPLE
done  output  1  high in DONE; results valid
pass  output  1  1 when done and fail_count == 0
fail_index  output  2  vector index of the first mismatch; 0 if none
fail_count  output  3  number of mismatching vectors, 0..4
observed  output  4  captured dut_out per vector; bit i = vector i

Behaviour:
- One clock. Reset is asynchronous and active-high. While reset is high: state=IDLE, vec=0, settle counter=0, and in_a, in_b, busy, done, pass, fail_index, fail_count and observed are all 0. No clock edge is needed.
- States: IDLE, APPLY, SETTLE, SAMPLE, DONE. Internal 2-bit vec, 4-bit settle counter, 1-bit first_fail_seen.
- IDLE/DONE with start=1 at an edge:
  - Next state is APPLY; vec←0; {in_a,in_b}←00.
  - observed, fail_count, fail_index and first_fail_seen are cleared; done←0.
- start is level-sampled only in IDLE/DONE. Any start in APPLY, SETTLE or SAMPLE is ignored. No queued restart.
- APPLY lasts exactly 1 cycle. Then state←SETTLE and counter←SETTLE_CYCLES-1.
- SETTLE: the counter decrements each edge. On the edge where it is 0, state←SAMPLE. SETTLE therefore lasts SETTLE_CYCLES cycles.
- SAMPLE lasts 1 cycle. On its exit edge:
  - observed[vec]←dut_out.
  - If dut_out != TRUTH_TABLE[vec]: fail_count←fail_count+1. If first_fail_seen=0, also fail_index←vec and first_fail_seen←1.
  - If vec<3: vec←vec+1, {in_a,in_b}←vec+1, state←APPLY.
  - If vec==3: state←DONE, and {in_a,in_b} is held at 11.
- Per vector: SETTLE_CYCLES+2 cycles. Each vector is held on in_a/in_b for exactly SETTLE_CYCLES+2 cycles.
- Run latency: done rises at the edge 4*(SETTLE_CYCLES+2) edges after the edge that accepted start. With default S=2 that is the 16th edge.
- pass is registered at the same edge as done: pass = (final fail_count == 0).
- DONE holds done, pass and all results until a new start or reset. A restart clears done at the accepting edge.
- fail_count saturates naturally at 4 and cannot wrap within a 3-bit field.
- dut_out is sampled only on the SAMPLE exit edge; values in other cycles are don't-care.
- Reset mid-run aborts the run with no partial results retained. The next start begins at vector 0.

Test Plan:
- Nand model on dut_out, defaults, 1-cycle start pulse:
  - in_a/in_b step 00,01,10,11, each held 4 cycles.
  - busy high 16 cycles; done at the 16th edge.
  - pass=1, observed=4'b0111, fail_count=0, fail_index=0.
- And model on dut_out, defaults -> observed=4'b1000, fail_count=4, fail_index=0, pass=0.
- dut_out tied 1, defaults -> observed=4'b1111, fail_count=1, fail_index=3, pass=0.
- start held high throughout:
  - Only one run occurs; after done, start is re-accepted on the next edge.
  - done falls at that edge, results clear, and vector 00 is driven again.
- reset pulsed asynchronously (between edges) during SETTLE of vector 2:
  - All outputs read 0 before the next edge.
  - After reset, a new start completes normally with pass=1 on the Nand model.
- SETTLE_CYCLES=1, TRUTH_TABLE=4'b0110 with an Xor model -> done at the 12th edge, each vector held 3 cycles, pass=1, observed=4'b0110.
